// File: rtl/substitui_bytes.sv
// AES SubBytes stage: each of the 16 state bytes is replaced by its forward S-box value.
// One-cycle registered latency; pronto pulses for every accepted block.
module substitui_bytes (
  input  logic         clk,
  input  logic         rst,
  input  logic         valido,
  input  logic [127:0] bloco,
  output logic [127:0] saida,
  output logic         pronto
);

  // Forward S-box, entry 0 in the most significant byte of the first row.
  localparam logic [0:255][7:0] sbox_rom = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] saida_d, saida_q;
  logic         pronto_d, pronto_q;

  always_comb begin
    saida_d  = saida_q;
    pronto_d = valido;
    if (valido) begin
      for (int k = 0; k < 16; k++) begin
        saida_d[8*k +: 8] = sbox_rom[bloco[8*k +: 8]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saida_q  <= 128'h0;
      pronto_q <= 1'b0;
    end else begin
      saida_q  <= saida_d;
      pronto_q <= pronto_d;
    end
  end

  assign saida  = saida_q;
  assign pronto = pronto_q;

endmodule

// File: tb/tb_substitui_bytes.sv
// Self-checking bench for substitui_bytes: directed vector table, hold, streaming and reset.
// The golden S-box is derived arithmetically (GF(2^8) inverse plus affine map).
module tb_substitui_bytes;

  logic         clk;
  logic         rst;
  logic         valido;
  logic [127:0] bloco;
  logic [127:0] saida;
  logic         pronto;

  int n_total;
  int n_pass;

  logic [7:0] gold [256];

  substitui_bytes dut (
    .clk    (clk),
    .rst    (rst),
    .valido (valido),
    .bloco  (bloco),
    .saida  (saida),
    .pronto (pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    // b^254 is the multiplicative inverse; it yields 0 for b = 0 as AES requires.
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, b);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] subbytes_model(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = gold[d[8*k +: 8]];
    return r;
  endfunction

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: saida=%h expected=%h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got=%b expected=%b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t         vecs [6];
    logic [127:0] held;
    logic [127:0] blk;

    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{"reference", 128'h52464943_45545345_54415256_414c4150,
                             128'h005a3b1a_6e20ed6e_208300b1_83298353};
    vecs[1] = '{"all_00", 128'h0, {16{8'h63}}};
    vecs[2] = '{"all_ff", {16{8'hff}}, {16{8'h16}}};
    vecs[3] = '{"all_01", {16{8'h01}}, {16{8'h7c}}};
    vecs[4] = '{"all_53", {16{8'h53}}, {16{8'hed}}};
    vecs[5] = '{"anchors", 128'h01ff5654_5352504c_49464543_41010000,
                           128'h7c16b120_ed005329_3b5a6e1a_837c6363};

    for (int i = 0; i < 256; i++) gold[i] = sbox_model(8'(i));

    // Reset held from time zero.
    rst    = 1'b1;
    valido = 1'b0;
    bloco  = 128'h0;
    #2;
    check128("reset_saida", saida, 128'h0);
    check1("reset_pronto", pronto, 1'b0);
    valido = 1'b1;
    bloco  = {16{8'hff}};
    tick();
    check128("reset_held_saida", saida, 128'h0);
    check1("reset_held_pronto", pronto, 1'b0);
    valido = 1'b0;
    #2 rst = 1'b0;

    // Directed table: one accepted block, then one idle edge.
    for (int i = 0; i < 6; i++) begin
      bloco  = vecs[i].din;
      valido = 1'b1;
      tick();
      check128({vecs[i].name, "_saida"}, saida, vecs[i].dout);
      check1({vecs[i].name, "_pronto"}, pronto, 1'b1);
      valido = 1'b0;
      bloco  = ~vecs[i].din;
      tick();
      check128({vecs[i].name, "_idle_saida"}, saida, vecs[i].dout);
      check1({vecs[i].name, "_idle_pronto"}, pronto, 1'b0);
    end

    // Hold: reference result must survive five idle cycles with changing input.
    bloco  = vecs[0].din;
    valido = 1'b1;
    tick();
    held   = vecs[0].dout;
    valido = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bloco = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check128("hold_saida", saida, held);
      check1("hold_pronto", pronto, 1'b0);
    end

    // Streaming: 256 back-to-back blocks, byte k = (i+k) mod 256.
    valido = 1'b1;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(i + k);
      bloco = blk;
      tick();
      check128($sformatf("stream_%0d_saida", i), saida, subbytes_model(blk));
      check1($sformatf("stream_%0d_pronto", i), pronto, 1'b1);
    end
    valido = 1'b0;
    tick();
    check1("stream_end_pronto", pronto, 1'b0);

    // Asynchronous reset between edges while saida is nonzero.
    #2 rst = 1'b1;
    #1;
    check128("async_rst_saida", saida, 128'h0);
    check1("async_rst_pronto", pronto, 1'b0);
    tick();
    #2 rst = 1'b0;
    bloco  = 128'h0;
    valido = 1'b1;
    tick();
    check128("post_rst_saida", saida, {16{8'h63}});
    check1("post_rst_pronto", pronto, 1'b1);
    valido = 1'b0;
    tick();
    check1("post_rst_idle_pronto", pronto, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
